// File: rtl/key_step_ctrl_pkg.sv
// Shared constants and FSM encoding for the debounced push-button step controller.
// Defaults target a 50 MHz core clock.
package key_step_ctrl_pkg;

    localparam int STEP_MAX_DEF     = 9;
    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int LONG_CYC_DEF     = 50_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_e;

    function automatic logic [3:0] next_step(input logic [3:0] cur, input logic [3:0] max);
        return (cur >= max) ? 4'd1 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/key_step_ctrl_if.sv
// Button-in / step-out bundle between the key source and the step controller.
// Outputs are one-cycle pulses plus a level step value; there is no backpressure.
interface key_step_ctrl_if;

    logic       key_in;
    logic       key_pulse;
    logic       long_press;
    logic [3:0] step;
    logic       step_vld;

    modport master (
        output key_in,
        input  key_pulse, long_press, step, step_vld
    );

    modport slave (
        input  key_in,
        output key_pulse, long_press, step, step_vld
    );

endinterface

// File: rtl/key_step_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, 2-cycle latency.
// Reset value is a parameter so an idle level can be presented during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_step_ctrl.sv
// Debounces an active-low key, pulses on short/long press and cycles a 1..STEP_MAX step.
// key_pulse appears DEBOUNCE_CYC+3 cycles after the key goes low; outputs never stall.
module key_step_ctrl
    import key_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter int STEP_MAX     = STEP_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    key_step_ctrl_if.slave kif
);

    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    // One extra count of headroom so hold_cnt can sit at LONG_CYC without wrapping.
    localparam int HOLD_W = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
    localparam logic [3:0]        STEP_TOP  = 4'(STEP_MAX);

    key_state_e        state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [3:0]        step_q;
    logic [3:0]        step_inc_d;
    logic              key_pulse_q;
    logic              long_press_q;
    logic              step_vld_q;
    logic              key_s;
    logic              holding;
    logic              rel_done;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (kif.key_in),
        .q_o   (key_s)
    );

    always_comb begin
        step_inc_d = next_step(step_q, STEP_TOP);
        holding    = (state_q == HELD) || (state_q == REL_DB);
        rel_done   = (state_q == REL_DB) && key_s && (db_cnt_q == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            step_q       <= 4'd1;
            key_pulse_q  <= 1'b0;
            long_press_q <= 1'b0;
            step_vld_q   <= 1'b0;
        end else begin
            key_pulse_q  <= 1'b0;
            long_press_q <= 1'b0;
            step_vld_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!key_s) begin
                        state_q  <= PRESS_DB;
                        db_cnt_q <= '0;
                    end
                end
                PRESS_DB: begin
                    if (key_s) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= HELD;
                        key_pulse_q <= 1'b1;
                        step_vld_q  <= 1'b1;
                        step_q      <= step_inc_d;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (key_s) begin
                        state_q  <= REL_DB;
                        db_cnt_q <= '0;
                    end
                end
                REL_DB: begin
                    if (!key_s) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Saturation at HOLD_SAT means HOLD_LAST is seen only once per press.
            if (rel_done) begin
                hold_cnt_q <= '0;
            end else if (holding) begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                end
                if (hold_cnt_q == HOLD_LAST) begin
                    long_press_q <= 1'b1;
                    step_vld_q   <= 1'b1;
                    step_q       <= 4'd1;
                end
            end
        end
    end

    assign kif.key_pulse  = key_pulse_q;
    assign kif.long_press = long_press_q;
    assign kif.step_vld   = step_vld_q;
    assign kif.step       = step_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl at DEBOUNCE_CYC=8, LONG_CYC=32, STEP_MAX=9.
module tb_key_step_ctrl;
    import key_step_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_step_ctrl_if kif ();

    key_step_ctrl #(
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (32),
        .STEP_MAX     (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int kp_cnt = 0, lp_cnt = 0, sv_cnt = 0, multi_hi = 0;
    int last_kp_cyc = -1, last_lp_cyc = -1;
    int kp_step = 0, lp_step = 0;
    logic pk = 1'b0, pl = 1'b0, pv = 1'b0;

    always @(negedge clk) begin
        if (kif.key_pulse === 1'b1) begin
            kp_cnt++;
            last_kp_cyc = cyc;
            kp_step     = int'(kif.step);
        end
        if (kif.long_press === 1'b1) begin
            lp_cnt++;
            last_lp_cyc = cyc;
            lp_step     = int'(kif.step);
        end
        if (kif.step_vld === 1'b1) sv_cnt++;
        if ((kif.key_pulse && pk) || (kif.long_press && pl) || (kif.step_vld && pv)) multi_hi++;
        pk = kif.key_pulse;
        pl = kif.long_press;
        pv = kif.step_vld;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k, s, r;
        int kp0, lp0, sv0;

        kif.key_in = 1'b1;
        rst_n      = 1'b0;
        step_clk(3);
        chk("rst_key_pulse", int'(kif.key_pulse), 0);
        chk("rst_long_press", int'(kif.long_press), 0);
        chk("rst_step_vld", int'(kif.step_vld), 0);
        chk("rst_step", int'(kif.step), 1);
        rst_n = 1'b1;
        step_clk(2);

        // Clean 20-cycle press
        kp0 = kp_cnt; lp0 = lp_cnt; sv0 = sv_cnt;
        k = cyc;
        kif.key_in = 1'b0;
        step_clk(20);
        kif.key_in = 1'b1;
        step_clk(14);
        chk("clean_kp_cycle", last_kp_cyc, k + 11);
        chk("clean_step", kp_step, 2);
        chk("clean_kp_count", kp_cnt - kp0, 1);
        chk("clean_sv_count", sv_cnt - sv0, 1);
        chk("clean_no_long", lp_cnt - lp0, 0);
        chk("clean_idle", int'(dut.state_q), int'(IDLE));

        // Short low glitches, then a stable press
        kp0 = kp_cnt; sv0 = sv_cnt;
        kif.key_in = 1'b0; step_clk(3);
        kif.key_in = 1'b1; step_clk(4);
        kif.key_in = 1'b0; step_clk(3);
        kif.key_in = 1'b1; step_clk(6);
        chk("glitch_no_kp", kp_cnt - kp0, 0);
        chk("glitch_no_sv", sv_cnt - sv0, 0);
        k = cyc;
        kif.key_in = 1'b0; step_clk(20);
        kif.key_in = 1'b1; step_clk(14);
        chk("glitch_then_kp", kp_cnt - kp0, 1);
        chk("glitch_kp_cycle", last_kp_cyc, k + 11);
        chk("glitch_step", kp_step, 3);

        // Nine short presses from reset wrap the step back to 1
        rst_n = 1'b0; step_clk(2);
        rst_n = 1'b1; step_clk(2);
        sv0 = sv_cnt;
        for (int i = 0; i < 9; i++) begin
            k = cyc;
            kif.key_in = 1'b0; step_clk(14);
            kif.key_in = 1'b1; step_clk(14);
            chk($sformatf("seq_step_%0d", i), kp_step, (i < 8) ? i + 2 : 1);
            chk($sformatf("seq_cycle_%0d", i), last_kp_cyc, k + 11);
        end
        chk("seq_sv_count", sv_cnt - sv0, 9);

        // Long hold of 100 cycles
        kp0 = kp_cnt; lp0 = lp_cnt; sv0 = sv_cnt;
        k = cyc;
        kif.key_in = 1'b0;
        step_clk(100);
        chk("long_kp_step", kp_step, 2);
        chk("long_kp_cycle", last_kp_cyc, k + 11);
        chk("long_lp_cycle", last_lp_cyc, k + 43);
        chk("long_lp_step", lp_step, 1);
        chk("long_lp_count", lp_cnt - lp0, 1);
        chk("long_sv_count", sv_cnt - sv0, 2);
        kif.key_in = 1'b1;
        step_clk(14);
        chk("long_single_lp", lp_cnt - lp0, 1);
        chk("long_single_kp", kp_cnt - kp0, 1);
        chk("long_final_step", int'(kif.step), 1);

        // Release with 2-cycle high bounces
        kp0 = kp_cnt; lp0 = lp_cnt;
        kif.key_in = 1'b0;
        step_clk(14);
        for (int i = 0; i < 2; i++) begin
            kif.key_in = 1'b1; step_clk(2);
            kif.key_in = 1'b0; step_clk(3);
        end
        kif.key_in = 1'b1;
        s = cyc;
        step_clk(10);
        chk("bounce_still_rel_db", int'(dut.state_q), int'(REL_DB));
        step_clk(1);
        chk("bounce_idle_after", int'(dut.state_q), int'(IDLE));
        chk("bounce_idle_cycle", cyc, s + 11);
        chk("bounce_kp_count", kp_cnt - kp0, 1);
        chk("bounce_no_long", lp_cnt - lp0, 0);
        chk("bounce_step", int'(kif.step), 2);

        // Reset during press debounce with key still low
        kif.key_in = 1'b0;
        step_clk(6);
        chk("mid_in_press_db", int'(dut.state_q), int'(PRESS_DB));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key_pulse", int'(kif.key_pulse), 0);
        chk("mid_rst_long_press", int'(kif.long_press), 0);
        chk("mid_rst_step_vld", int'(kif.step_vld), 0);
        chk("mid_rst_step", int'(kif.step), 1);
        chk("mid_rst_state", int'(dut.state_q), int'(IDLE));
        step_clk(2);
        kp0 = kp_cnt;
        rst_n = 1'b1;
        r = cyc;
        step_clk(16);
        chk("mid_kp_cycle", last_kp_cyc, r + 11);
        chk("mid_kp_count", kp_cnt - kp0, 1);
        chk("mid_kp_step", kp_step, 2);
        kif.key_in = 1'b1;
        step_clk(14);

        chk("no_back_to_back_pulses", multi_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_step_ctrl.md
KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1_000_000, meaning stable-level cycles needed to accept a press or release (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYC, default 50_000_000, meaning held cycles after accepted press that qualify a long press (1 s).
REQ-003 SHALL have parameter STEP_MAX, default 9, meaning highest step value before wrap.
REQ-004 SHALL have port clk  input  1  system clock; the block uses only this one clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_in  input  1  raw push-button, active-low, asynchronous to clk.
REQ-007 SHALL have port key_pulse  output  1  one-cycle pulse per accepted short press.
REQ-008 SHALL have port long_press  output  1  one-cycle pulse per qualified long press.
REQ-009 SHALL have port step  output  4  current step value, 1..STEP_MAX, for the downstream LED on-time selector.
REQ-010 SHALL have port step_vld  output  1  one-cycle pulse in the cycle step takes a new value.

Function
REQ-011 SHALL synchronise key_in through two flops (key_s), both resetting to 1 (released).
REQ-012 SHALL implement FSM states IDLE, PRESS_DB, HELD, REL_DB; reset state IDLE.
REQ-013 IDLE: key_s=0 -> PRESS_DB with db_cnt cleared; otherwise stay.
REQ-014 PRESS_DB: key_s=1 -> IDLE with no outputs (bounce reject); db_cnt increments while key_s=0; at db_cnt=DEBOUNCE_CYC-1 -> HELD.
REQ-015 On the PRESS_DB->HELD transition, key_pulse and step_vld SHALL be high in the next cycle, with step = step+1, or 1 if step was STEP_MAX.
REQ-016 Latency: with key_in held low from edge k, key_pulse SHALL be high in exactly cycle k+DEBOUNCE_CYC+3.
REQ-017 HELD: hold_cnt increments, saturating at LONG_CYC; hold_cnt reaching LONG_CYC-1 SHALL pulse long_press and step_vld once, with step forced to 1.
REQ-018 Only one long_press SHALL occur per accepted press, however long the key is held.
REQ-019 HELD: key_s=1 -> REL_DB with db_cnt cleared; hold_cnt keeps running in REL_DB.
REQ-020 REL_DB: key_s=0 -> HELD with no new pulse (release bounce); at db_cnt=DEBOUNCE_CYC-1 with key_s=1 -> IDLE, clearing hold_cnt.
REQ-021 A long press SHALL first produce the short-press increment (REQ-015), then the reset to 1 (REQ-017); step_vld fires both times.
REQ-022 key_pulse, long_press and step_vld SHALL be registered outputs, never high for more than one consecutive cycle.
REQ-023 Counter widths SHALL be $clog2 of their terminal value; no counter SHALL wrap.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, db_cnt=0, hold_cnt=0, sync flops=1, key_pulse=0, long_press=0, step_vld=0, step=1.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of reset with key still low, a new full debounce SHALL be required.

Structure
REQ-026 The shared package/header SHALL hold STEP_MAX, default DEBOUNCE_CYC/LONG_CYC for 50 MHz, and the FSM state encodings.
REQ-027 The two-flop synchroniser SHALL be a separate sub-module, sync_2ff, with reset value parameter.

Verification (sim params DEBOUNCE_CYC=8, LONG_CYC=32, STEP_MAX=9)
REQ-028 Clean press of 20 cycles from reset -> key_pulse and step_vld at cycle 11, step 1->2, no long_press.
REQ-029 Press with 3-cycle low glitches before a stable press -> glitches produce no pulses; one key_pulse after the stable press.
REQ-030 Nine short presses from reset -> step sequence 2,3,...,9,1; exactly nine step_vld pulses.
REQ-031 Hold 100 cycles -> key_pulse (step 2), then long_press plus step_vld with step=1, 32 cycles into HELD; no second long_press.
REQ-032 Release with 2-cycle high bounces -> no extra key_pulse; FSM returns to IDLE only after 8 stable-high cycles.
REQ-033 rst_n pulsed low during PRESS_DB with key held -> all outputs at reset values, step=1; key_pulse exactly 11 cycles after rst_n deasserts.
